// File: rtl/elevator_pkg.sv
// Shared constants and state type for the elevator request path.
// Optional build macro used by call_scheduler: CALL_SCHED_EMERG_FLUSH_EN.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = $clog2(NUM_FLOORS);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DWELL
  } sched_state_t;

endpackage

// File: rtl/floor_pick.sv
// Combinational SCAN helpers: nearest pending floor above and below the
// car, plus whether the car's own floor is pending.
module floor_pick
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    up_tgt,
  output logic                  up_hit,
  output logic [FLOOR_W-1:0]    dn_tgt,
  output logic                  dn_hit,
  output logic                  here
);

  // Scanning downward leaves the lowest floor above; scanning upward leaves the highest below.
  always_comb begin
    up_tgt = '0;
    up_hit = 1'b0;
    dn_tgt = '0;
    dn_hit = 1'b0;
    here   = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
        up_tgt = FLOOR_W'(i);
        up_hit = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
        dn_tgt = FLOOR_W'(i);
        dn_hit = 1'b1;
      end
      if (pending[i] && (FLOOR_W'(i) == cur_floor)) begin
        here = 1'b1;
      end
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// SCAN-ordered request scheduler feeding the elevator's call input.
// Define CALL_SCHED_EMERG_FLUSH_EN to drop all requests when emergency rises.
module call_scheduler
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  door_open,
  input  logic                  emergency,
  output logic [FLOOR_W-1:0]    call,
  output logic                  call_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  sweep_up
);

  sched_state_t          state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] floor_clr, btn_eff;
  logic [FLOOR_W-1:0]    call_q, call_d;
  logic                  call_valid_q, call_valid_d;
  logic                  sweep_up_q, sweep_up_d;
  logic [3:0]            dwell_q, dwell_d;
  logic [FLOOR_W-1:0]    up_tgt, dn_tgt;
  logic                  up_hit, dn_hit, here, arrival;
`ifdef CALL_SCHED_EMERG_FLUSH_EN
  logic                  emerg_q, emerg_d;
`endif

  floor_pick u_pick (
    .pending   (pending_q),
    .cur_floor (cur_floor),
    .up_tgt    (up_tgt),
    .up_hit    (up_hit),
    .dn_tgt    (dn_tgt),
    .dn_hit    (dn_hit),
    .here      (here)
  );

  // A door opening at a floor clears it, beating a same-cycle press.
  always_comb begin
    floor_clr = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      floor_clr[i] = door_open && (cur_floor == FLOOR_W'(i));
    end
`ifdef CALL_SCHED_EMERG_FLUSH_EN
    btn_eff = emergency ? '0 : btn_req;
    emerg_d = emergency;
    if (emergency && !emerg_q) pending_d = '0;
    else                       pending_d = (pending_q | btn_eff) & ~floor_clr;
`else
    btn_eff   = btn_req;
    pending_d = (pending_q | btn_eff) & ~floor_clr;
`endif
  end

  assign arrival = door_open && (cur_floor == call_q) && call_valid_q && (state_q != DWELL);

  always_comb begin
    state_d      = state_q;
    call_d       = call_q;
    call_valid_d = call_valid_q;
    sweep_up_d   = sweep_up_q;
    dwell_d      = dwell_q;
    if (emergency) begin
      state_d      = IDLE;
      call_valid_d = 1'b0;
      dwell_d      = '0;
    end else if (arrival) begin
      state_d = DWELL;
      dwell_d = 4'(DWELL_CYCLES - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pending_q == '0) begin
            call_valid_d = 1'b0;
          end else if (here) begin
            call_d       = cur_floor;
            call_valid_d = 1'b1;
          end else if (up_hit && (sweep_up_q || !dn_hit)) begin
            state_d      = UP;
            sweep_up_d   = 1'b1;
            call_d       = up_tgt;
            call_valid_d = 1'b1;
          end else begin
            state_d      = DOWN;
            sweep_up_d   = 1'b0;
            call_d       = dn_tgt;
            call_valid_d = 1'b1;
          end
        end
        UP: begin
          if (up_hit) begin
            call_d       = up_tgt;
            call_valid_d = 1'b1;
          end else if (dn_hit) begin
            state_d      = DOWN;
            sweep_up_d   = 1'b0;
            call_d       = dn_tgt;
            call_valid_d = 1'b1;
          end else begin
            state_d      = IDLE;
            call_valid_d = 1'b0;
          end
        end
        DOWN: begin
          if (dn_hit) begin
            call_d       = dn_tgt;
            call_valid_d = 1'b1;
          end else if (up_hit) begin
            state_d      = UP;
            sweep_up_d   = 1'b1;
            call_d       = up_tgt;
            call_valid_d = 1'b1;
          end else begin
            state_d      = IDLE;
            call_valid_d = 1'b0;
          end
        end
        DWELL: begin
          if (dwell_q == '0) state_d = IDLE;
          else               dwell_d = dwell_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      call_q       <= '0;
      call_valid_q <= 1'b0;
      sweep_up_q   <= 1'b1;
      dwell_q      <= '0;
`ifdef CALL_SCHED_EMERG_FLUSH_EN
      emerg_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      call_q       <= call_d;
      call_valid_q <= call_valid_d;
      sweep_up_q   <= sweep_up_d;
      dwell_q      <= dwell_d;
`ifdef CALL_SCHED_EMERG_FLUSH_EN
      emerg_q      <= emerg_d;
`endif
    end
  end

  assign call       = call_q;
  assign call_valid = call_valid_q;
  assign pending    = pending_q;
  assign sweep_up   = sweep_up_q;

endmodule
